// File: rtl/wavetable_arbiter_if.sv
// Voice request / RAM read bus shared by the wavetable arbiter.
// The slave side is the arbiter; the master side drives requests and RDATA.
interface wavetable_arbiter_if #(
    parameter int NVOICE    = 4,
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 16
);
    logic [NVOICE-1:0]           req;
    logic [NVOICE*ADDRWIDTH-1:0] req_addr;
    logic [NVOICE*2-1:0]         req_bank;
    logic [NVOICE-1:0]           gnt;
    logic [NVOICE-1:0]           valid;
    logic [DATAWIDTH-1:0]        sample;
    logic [ADDRWIDTH-1:0]        RADDR;
    logic [1:0]                  rbank;
    logic                        RCLK;
    logic [DATAWIDTH-1:0]        RDATA;

    modport slave (
        input  req, req_addr, req_bank, RDATA,
        output gnt, valid, sample, RADDR, rbank, RCLK
    );

    modport master (
        output req, req_addr, req_bank, RDATA,
        input  gnt, valid, sample, RADDR, rbank, RCLK
    );
endinterface

// File: rtl/wavetable_arbiter.sv
// Round-robin arbiter sharing one wavetable RAM between oscillator voices.
// Each read takes four cycles: IDLE, SETUP, STROBE, CAPTURE.
module wavetable_arbiter #(
    parameter int NVOICE    = 4,
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    wavetable_arbiter_if.slave bus
);
    localparam int PW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] STROBE  = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win;
    logic [PW-1:0]        pick;
    logic                 any;
    int                   idx;
    logic [NVOICE-1:0]    gnt_q;
    logic [NVOICE-1:0]    valid_q;
    logic [DATAWIDTH-1:0] sample_q;
    logic [ADDRWIDTH-1:0] raddr_q;
    logic [1:0]           rbank_q;
    logic                 rclk_q;

    // Search starts one past the last winner so every voice gets a turn.
    always_comb begin
        pick = ptr;
        any  = 1'b0;
        idx  = 0;
        for (int i = 1; i <= NVOICE; i++) begin
            idx = (int'(ptr) + i) % NVOICE;
            if (!any && bus.req[idx]) begin
                any  = 1'b1;
                pick = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= PW'(NVOICE - 1);
            win      <= '0;
            gnt_q    <= '0;
            valid_q  <= '0;
            sample_q <= '0;
            raddr_q  <= '0;
            rbank_q  <= '0;
            rclk_q   <= 1'b0;
        end else begin
            valid_q <= '0;
            rclk_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        raddr_q <= bus.req_addr[int'(pick)*ADDRWIDTH +: ADDRWIDTH];
                        rbank_q <= bus.req_bank[int'(pick)*2 +: 2];
                        gnt_q   <= NVOICE'(1) << pick;
                        win     <= pick;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // Strobe is registered so the RAM sees a clean pulse.
                    rclk_q <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    sample_q <= bus.RDATA;
                    valid_q  <= gnt_q;
                    gnt_q    <= '0;
                    ptr      <= win;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.valid  = valid_q;
    assign bus.sample = sample_q;
    assign bus.RADDR  = raddr_q;
    assign bus.rbank  = rbank_q;
    assign bus.RCLK   = rclk_q;
endmodule

// File: tb/tb_wavetable_arbiter.sv
// Directed bench for wavetable_arbiter with a one-cycle-latency RAM model.
// RAM word = {4'hA, 2'b00, bank, addr}; RDATA is 16'hDEAD when not strobed.
module tb_wavetable_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    wavetable_arbiter_if #(.NVOICE(4), .ADDRWIDTH(8), .DATAWIDTH(16)) bus ();

    wavetable_arbiter #(.NVOICE(4), .ADDRWIDTH(8), .DATAWIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.RCLK)
            bus.RDATA <= {4'hA, 2'b00, bus.rbank, bus.RADDR};
        else
            bus.RDATA <= 16'hDEAD;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in an IDLE cycle with req already driven; ends in the valid cycle.
    task automatic service(input int v, input logic [7:0] a,
                           input logic [1:0] b, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << v;
        step();
        chk("setup_gnt", 32'(bus.gnt), 32'(oh));
        chk("setup_raddr", 32'(bus.RADDR), 32'(a));
        chk("setup_rbank", 32'(bus.rbank), 32'(b));
        chk("setup_rclk", 32'(bus.RCLK), 32'd0);
        step();
        chk("strobe_rclk", 32'(bus.RCLK), 32'd1);
        chk("strobe_valid", 32'(bus.valid), 32'd0);
        step();
        chk("capture_rclk", 32'(bus.RCLK), 32'd0);
        chk("capture_gnt", 32'(bus.gnt), 32'(oh));
        if (drop) bus.req = 4'b0000;
        step();
        chk("valid", 32'(bus.valid), 32'(oh));
        chk("gnt_clear", 32'(bus.gnt), 32'd0);
        chk("sample", 32'(bus.sample), {16'h0, 4'hA, 2'b00, b, a});
    endtask

    initial begin
        int order [5];
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_bank = '0;
        bus.RDATA    = 16'hDEAD;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_sample", 32'(bus.sample), 32'd0);
        chk("rst_raddr", 32'(bus.RADDR), 32'd0);
        chk("rst_rbank", 32'(bus.rbank), 32'd0);
        chk("rst_rclk", 32'(bus.RCLK), 32'd0);
        rst = 1'b0;
        step();

        // Single voice 0 read; address changes after IDLE must not leak.
        bus.req      = 4'b0001;
        bus.req_addr = 32'h0000_0010;
        bus.req_bank = 8'b00_00_00_01;
        step();
        chk("s1_gnt", 32'(bus.gnt), 32'h1);
        chk("s1_raddr", 32'(bus.RADDR), 32'h10);
        chk("s1_rbank", 32'(bus.rbank), 32'h1);
        chk("s1_rclk_c1", 32'(bus.RCLK), 32'd0);
        bus.req_addr = 32'h0000_00FF;
        bus.req_bank = 8'b00_00_00_11;
        step();
        chk("s1_rclk_c2", 32'(bus.RCLK), 32'd1);
        chk("s1_raddr_hold", 32'(bus.RADDR), 32'h10);
        chk("s1_rbank_hold", 32'(bus.rbank), 32'h1);
        step();
        chk("s1_rclk_c3", 32'(bus.RCLK), 32'd0);
        chk("s1_valid_c3", 32'(bus.valid), 32'd0);
        bus.req = 4'b0000;
        step();
        chk("s1_valid_c4", 32'(bus.valid), 32'h1);
        chk("s1_sample", 32'(bus.sample), 32'hA110);
        step();
        chk("s1_valid_off", 32'(bus.valid), 32'd0);
        chk("s1_idle_rclk", 32'(bus.RCLK), 32'd0);
        chk("s1_sample_hold", 32'(bus.sample), 32'hA110);

        // 0xFF address and bank 3 pass straight through.
        bus.req = 4'b0001;
        service(0, 8'hFF, 2'b11, 1'b1);
        step();

        // All voices requesting from reset: 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_addr = 32'h2322_2120;
        bus.req_bank = 8'b11_10_01_00;
        bus.req      = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            service(order[k], 8'h20 + 8'(order[k]), 2'(order[k]), k == 4);
        step();
        chk("rr_idle_gnt", 32'(bus.gnt), 32'd0);

        // Voice 2 served, then 0101 goes to voice 0, 2, then 0 again.
        bus.req = 4'b0100;
        service(2, 8'h22, 2'd2, 1'b1);
        bus.req = 4'b0101;
        service(0, 8'h20, 2'd0, 1'b0);
        service(2, 8'h22, 2'd2, 1'b0);
        service(0, 8'h20, 2'd0, 1'b1);
        step();

        // Reset during STROBE aborts the read and restores voice 0 priority.
        bus.req = 4'b0010;
        step();
        chk("ab_gnt", 32'(bus.gnt), 32'h2);
        step();
        chk("ab_rclk", 32'(bus.RCLK), 32'd1);
        rst = 1'b1;
        step();
        chk("ab_gnt0", 32'(bus.gnt), 32'd0);
        chk("ab_valid0", 32'(bus.valid), 32'd0);
        chk("ab_rclk0", 32'(bus.RCLK), 32'd0);
        chk("ab_raddr0", 32'(bus.RADDR), 32'd0);
        chk("ab_rbank0", 32'(bus.rbank), 32'd0);
        chk("ab_sample0", 32'(bus.sample), 32'd0);
        rst     = 1'b0;
        bus.req = 4'b1111;
        service(0, 8'h20, 2'd0, 1'b1);
        step();
        chk("end_valid", 32'(bus.valid), 32'd0);
        chk("end_rclk", 32'(bus.RCLK), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wavetable_arbiter.md
WAVETABLE_ARBITER -- requirements
Module: wavetable_arbiter

Interface
REQ-001 SHALL have parameter NVOICE, default 4, giving the number of requesting oscillator voices (fixed at 4 for this revision).
REQ-002 SHALL have parameter ADDRWIDTH, default 8, giving the wavetable position width.
REQ-003 SHALL have parameter DATAWIDTH, default 16, giving the sample width.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NVOICE  per-voice read request, held by the voice until its valid pulse.
REQ-007 req_addr  input  NVOICE*ADDRWIDTH  per-voice wavetable position; voice i occupies bits [i*8+7:i*8].
REQ-008 req_bank  input  NVOICE*2  per-voice table bank; voice i occupies bits [i*2+1:i*2].
REQ-009 gnt  output  NVOICE  one-hot, high for the whole service of the granted voice.
REQ-010 valid  output  NVOICE  one-hot, one-cycle pulse marking sample return to voice i.
REQ-011 sample  output  DATAWIDTH  last captured RAM word; held between captures.
REQ-012 RADDR  output  ADDRWIDTH  shared RAM read address.
REQ-013 rbank  output  2  shared RAM bank select.
REQ-014 RCLK  output  1  RAM read strobe.
REQ-015 RDATA  input  DATAWIDTH  RAM read data, valid on the cycle after the RCLK-high cycle.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, STROBE and CAPTURE, with one state per clock cycle outside IDLE.
REQ-017 In IDLE, with any req bit high, SHALL select a winner, latch its addr/bank into RADDR/rbank, set gnt[winner], and go to SETUP; with no req bit high it stays in IDLE.
REQ-018 SETUP: SHALL hold RADDR and rbank stable with RCLK=0, then go to STROBE.
REQ-019 STROBE: SHALL drive RCLK=1 for exactly one cycle, then go to CAPTURE.
REQ-020 CAPTURE: SHALL drive RCLK=0, register RDATA into sample at the cycle-ending edge, register valid[winner]=1, clear gnt, update the pointer, and go to IDLE.
REQ-021 Latency SHALL be exactly 4 cycles, from the IDLE cycle that sees req to the cycle in which valid is high; valid and the updated sample appear in the same cycle.
REQ-022 Throughput SHALL be one read per 4 cycles: IDLE concurrent with a valid pulse may accept the next request.
REQ-023 Arbitration SHALL be round-robin: priority search starts at pointer+1 mod NVOICE, and pointer = last winner.
REQ-024 Simultaneous requests SHALL be granted in rotating order; no voice waits more than NVOICE services.
REQ-025 A requester deasserting req mid-service SHALL NOT abort the service; the valid pulse still issues.
REQ-026 A voice whose req is still high in the IDLE cycle after its own valid pulse SHALL be treated as a new request, and SHALL win only if it is next in rotation among active requesters.
REQ-027 req_addr and req_bank SHALL be sampled only in IDLE; later changes SHALL NOT affect RADDR/rbank during service.
REQ-028 RADDR wrap (0xFF) and bank values SHALL pass through unmodified, with no arithmetic.
REQ-029 gnt and valid SHALL each be one-hot or zero at all times.

Reset
REQ-030 On rst high at a clock edge: state=IDLE, RADDR=0, rbank=0, RCLK=0, gnt=0, valid=0, sample=0, pointer=NVOICE-1 (voice 0 has first priority).
REQ-031 rst asserted mid-service SHALL abort with no valid pulse, and the RAM read in flight SHALL be discarded.
REQ-032 rst SHALL take priority over every FSM transition.

Verification
REQ-033 Reset, then req=0001, req_addr[7:0]=0x10, bank0=1 -> RADDR=0x10, rbank=1, RCLK high exactly on cycle 2, valid=0001 on cycle 4, sample = RDATA present on cycle 3.
REQ-034 req=1111 held continuously -> grant order 0,1,2,3,0..., one valid every 4 cycles, no voice skipped.
REQ-035 With voice 2 just served, req=0101 -> voice 0 granted next (search starts at 3), then voice 2.
REQ-036 req_addr changes to 0xFF during SETUP/STROBE -> RADDR keeps the value latched in IDLE; a following service with 0xFF -> RADDR=0xFF with no wrap artefacts.
REQ-037 rst pulsed in STROBE -> no valid pulse, all outputs zero next cycle, next request served from voice 0 priority.
REQ-038 req deasserted during CAPTURE -> valid still pulses for that voice, then FSM idles with RCLK=0.
